// File: rtl/pc_fetch_if.sv
// Instruction-memory request handshake between the fetch unit and imem.
interface pc_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;

  modport master (output req, output addr, input ready);
  modport slave  (input req, input addr, output ready);
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC generator: sequential fetch, branch/jump redirect with
// pipeline squash, misaligned-target trap and a redirect perf counter.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump_en,
  input  logic [31:0]      jump_target,
  pc_fetch_if.master       imem,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus4,
  output logic             if_valid,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             misalign_exc,
  output logic [31:0]      exc_pc,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic [1:0] {RUN = 2'd0, WAIT = 2'd1, TRAP = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        redir;
  logic [31:0] tgt;
  logic        tgt_misal;
  logic        trapped;
  logic        req;

  // EX-stage branch is older than the ID-stage jump, so it wins.
  assign redir     = branch_taken | jump_en;
  assign tgt       = branch_taken ? branch_target : jump_target;
  assign tgt_misal = tgt[1:0] != 2'b00;
  assign trapped   = state == TRAP;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (redir && tgt_misal)       state_nxt = TRAP;
        else if (req && !imem.ready)  state_nxt = WAIT;
      end
      WAIT: begin
        if (redir && tgt_misal)       state_nxt = TRAP;
        else if (imem.ready || redir) state_nxt = RUN;
      end
      TRAP:    state_nxt = TRAP;
      default: state_nxt = RUN;
    endcase
  end

  // Output logic
  always_comb begin
    req         = !trapped && !stall && !redir && !rst;
    if_valid    = req && imem.ready;
    flush_if_id = redir && !trapped && !rst;
    flush_id_ex = branch_taken && !trapped && !rst;
  end

  assign imem.req  = req;
  assign imem.addr = pc;
  assign pc_out    = pc;
  assign pc_plus4  = pc + 32'd4;

  // A redirect overrides stall and abandons any in-flight fetch, since
  // req is already low whenever redir is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC;
      redirect_count <= '0;
      exc_pc         <= 32'd0;
      misalign_exc   <= 1'b0;
    end else begin
      misalign_exc <= 1'b0;
      if (trapped) begin
        pc <= pc;
      end else if (redir && !tgt_misal) begin
        pc             <= tgt;
        redirect_count <= redirect_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (redir) begin
        misalign_exc <= 1'b1;
        exc_pc       <= tgt;
      end else if (!stall && if_valid) begin
        pc <= pc_plus4;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_en;
  logic [31:0] jump_target;
  logic [31:0] pc_out, pc_plus4, exc_pc;
  logic        if_valid, flush_if_id, flush_id_ex, misalign_exc;
  logic [31:0] redirect_count;

  int passed = 0;
  int total  = 0;

  pc_fetch_if imem ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .imem          (imem.master),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .if_valid      (if_valid),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .misalign_exc  (misalign_exc),
    .exc_pc        (exc_pc),
    .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic st, input logic bt, input logic [31:0] btgt,
                       input logic je, input logic [31:0] jtgt, input logic rdy);
    @(negedge clk);
    stall = st; branch_taken = bt; branch_target = btgt;
    jump_en = je; jump_target = jtgt; imem.ready = rdy;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    jump_en = 1'b0; jump_target = 32'd0; imem.ready = 1'b1;
    tick(); tick();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_cnt", redirect_count, 32'h0);
    chk("rst_excpc", exc_pc, 32'h0);
    chk("rst_misal", {31'd0, misalign_exc}, 32'd0);
    chk("rst_req", {31'd0, imem.req}, 32'd0);
    chk("rst_ifv", {31'd0, if_valid}, 32'd0);

    // Sequential fetch at one per cycle
    @(negedge clk); rst = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      chk("seq_addr", imem.addr, 32'(i * 4));
      chk("seq_ifv", {31'd0, if_valid}, 32'd1);
      chk("seq_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd0);
      tick();
    end
    chk("seq_pc10", pc_out, 32'h10);

    // Taken branch to 0x100
    drive(1'b0, 1'b1, 32'h100, 1'b0, 32'd0, 1'b1);
    chk("br_ifv", {31'd0, if_valid}, 32'd0);
    chk("br_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd3);
    tick();
    chk("br_addr", imem.addr, 32'h100);
    chk("br_cnt", redirect_count, 32'd1);

    // Branch beats jump, stall ignored
    drive(1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1);
    chk("bj_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd3);
    tick();
    chk("bj_pc", pc_out, 32'h200);
    chk("bj_cnt", redirect_count, 32'd2);

    // Jump to 0x40 kills only IF/ID
    drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h40, 1'b1);
    chk("jmp_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd2);
    tick();
    chk("jmp_pc", pc_out, 32'h40);
    chk("jmp_cnt", redirect_count, 32'd3);

    // Memory wait: address held
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      chk("wait_addr", imem.addr, 32'h40);
      chk("wait_req", {31'd0, imem.req}, 32'd1);
      chk("wait_ifv", {31'd0, if_valid}, 32'd0);
      tick();
    end
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    chk("wait_rdy_ifv", {31'd0, if_valid}, 32'd1);
    tick();
    chk("wait_pc44", pc_out, 32'h44);

    // Stall
    drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    chk("stall_req", {31'd0, imem.req}, 32'd0);
    tick();
    chk("stall_pc", pc_out, 32'h44);

    // Wrap at top of address space
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b1);
    tick();
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    chk("wrap_cnt", redirect_count, 32'd4);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    tick();
    chk("wrap_pc0", pc_out, 32'h0);
    tick();
    chk("wrap_pc4", pc_out, 32'h4);

    // Misaligned jump traps
    drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h102, 1'b1);
    chk("mis_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd2);
    tick();
    chk("mis_exc", {31'd0, misalign_exc}, 32'd1);
    chk("mis_excpc", exc_pc, 32'h102);
    chk("mis_pc", pc_out, 32'h4);
    chk("mis_cnt", redirect_count, 32'd4);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    chk("trap_req", {31'd0, imem.req}, 32'd0);
    tick();
    chk("trap_pulse", {31'd0, misalign_exc}, 32'd0);
    chk("trap_excpc", exc_pc, 32'h102);
    drive(1'b0, 1'b1, 32'h500, 1'b0, 32'd0, 1'b1);
    chk("trap_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd0);
    chk("trap_ifv", {31'd0, if_valid}, 32'd0);
    tick();
    chk("trap_pc", pc_out, 32'h4);
    chk("trap_cnt", redirect_count, 32'd4);

    // Reset leaves trap
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    rst = 1'b1;
    tick();
    chk("rst2_pc", pc_out, 32'h0);
    chk("rst2_cnt", redirect_count, 32'd0);
    chk("rst2_excpc", exc_pc, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst2_ifv", {31'd0, if_valid}, 32'd1);
    tick();
    chk("rst2_pc4", pc_out, 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Fetch-stage PC generator; sits directly downstream of the EX-stage branch resolver and consumes its branch_taken decision and branch target.
- Holds the architectural fetch PC and drives the instruction-memory request handshake.
- Redirects on taken branches and jumps, squashes wrong-path instructions in IF/ID and ID/EX, traps on misaligned targets, and counts redirects for performance monitoring.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the redirect performance counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit stall; hold PC, no new request.
- branch_taken  input  1  taken-branch decision from EX-stage branch control.
- branch_target  input  32  branch target computed in EX.
- jump_en  input  1  JAL/JALR redirect request from ID.
- jump_target  input  32  jump target.
- imem_ready  input  1  instruction memory accepts/returns the current request this cycle.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address (equals pc_out).
- pc_out  output  32  current fetch PC.
- pc_plus4  output  32  pc_out + 4, modulo 2^32.
- if_valid  output  1  fetched instruction is valid for IF/ID this cycle.
- flush_if_id  output  1  squash the IF/ID register.
- flush_id_ex  output  1  squash the ID/EX register.
- misalign_exc  output  1  one-cycle pulse: misaligned redirect target.
- exc_pc  output  32  offending target address, held after trap.
- redirect_count  output  CNT_W  number of accepted redirects, wraps.

Behaviour:
- Reset (rst=1 at clock edge):
  - pc_out = RESET_PC; state = RUN; redirect_count = 0; exc_pc = 0; misalign_exc = 0.
  - imem_req, if_valid, flush_if_id and flush_id_ex are forced 0 while rst is high.
  - Reset mid-trap or mid-request abandons all state.
- States:
  - RUN: fetching normally.
  - WAIT: request outstanding, imem_ready low.
  - TRAP: halted after a misaligned redirect.
  - RUN→WAIT when imem_req=1 and imem_ready=0; WAIT→RUN on imem_ready=1 or on redirect.
  - Any state except TRAP goes to TRAP on a misaligned redirect. TRAP is exited only by rst.
- Redirect selection:
  - redir = branch_taken | jump_en.
  - tgt = branch_target if branch_taken, else jump_target. branch_taken wins because the EX instruction is older than the ID one.
- Combinational outputs:
  - imem_req = (state != TRAP) & ~stall & ~redir & ~rst.
  - imem_addr = pc_out.
  - if_valid = imem_req & imem_ready.
  - flush_if_id = redir & (state != TRAP).
  - flush_id_ex = branch_taken & (state != TRAP). A jump from ID kills only IF/ID.
- PC update priority (highest first):
  1. rst.
  2. TRAP: hold.
  3. redir with tgt[1:0]==0: pc ← tgt; redirect_count += 1. Overrides stall; any in-flight fetch is abandoned and if_valid is 0 that cycle.
  4. redir with tgt[1:0]!=0: pc held; next cycle misalign_exc=1 for exactly one cycle and exc_pc=tgt; state ← TRAP; counter unchanged.
  5. stall: hold.
  6. if_valid: pc ← pc + 4.
  7. Otherwise hold.
- In WAIT, imem_addr must stay stable until imem_ready is high or a redirect occurs.
- Latency: a redirect is visible on imem_addr one cycle after redir is sampled. Sequential fetch runs at one instruction per cycle while imem_ready=1.
- Arithmetic: pc + 4 wraps 32'hFFFF_FFFC → 32'h0000_0000; redirect_count wraps at 2^CNT_W.

Test Plan:
- Reset then imem_ready=1 for 4 cycles → imem_addr 0x0,0x4,0x8,0xC; if_valid=1 each cycle; flushes 0.
- At pc=0x10, branch_taken=1 with target 0x100 for 1 cycle → that cycle: if_valid=0, flush_if_id=flush_id_ex=1. Next cycle: imem_addr=0x100, redirect_count=1.
- branch_taken=1 (0x200) and jump_en=1 (0x300) in the same cycle, stall=1 → pc=0x200 next cycle; flush_id_ex=1; stall ignored.
- jump_en=1 target 0x102 → flush_if_id=1, flush_id_ex=0. Next cycle: misalign_exc=1, exc_pc=0x102. Afterwards: imem_req=0 and pc frozen while imem_ready=1 and further branches are applied; rst returns pc to RESET_PC.
- imem_ready=0 for 3 cycles at pc=0x40 → imem_addr held at 0x40, if_valid=0. Raising ready → if_valid=1, then pc=0x44. stall=1 → imem_req=0, pc held.
- pc forced to 0xFFFF_FFFC via branch, ready=1 → next pc=0x0, pc_plus4 wraps accordingly.
